// File: rtl/divider_32.sv
// divider_32: iterative 64-by-32 unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   start      request, sampled only while idle
//   dividend   64-bit unsigned dividend, latched on the accepting edge
//   divisor    32-bit unsigned divisor, latched on the accepting edge
//   busy       high while running or presenting a result
//   done       one-cycle pulse, results valid
//   quotient   32-bit quotient, held until the next accept
//   remainder  32-bit remainder, held until the next accept
//   overflow   quotient did not fit in 32 bits
//   div_zero   divisor was zero (only when DIV_ZERO_FLAG_EN is defined, else tied 0)
//
// Build option: define DIV_ZERO_FLAG_EN to report a zero divisor separately from overflow.

module divider_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        overflow,
  output logic        div_zero
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // Partial remainder; R < divisor always holds, so 32 stored bits suffice.
  logic [31:0] rem_q, rem_d;
  // Dividend low half shifting out at the top, quotient bits shifting in at the bottom.
  logic [31:0] sh_q, sh_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rmd_q, rmd_d;
  logic        ovf_q, ovf_d;
  logic        dz_q, dz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        zero_hit;
  logic [32:0] r_shift;
  logic [31:0] r_diff;
  logic        q_bit;

`ifdef DIV_ZERO_FLAG_EN
  assign zero_hit = (divisor == 32'd0);
`else
  // Zero divisor falls through to the overflow check (hi >= 0 is always true).
  assign zero_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    r_shift = {rem_q, sh_q[31]};
    q_bit   = (r_shift >= {1'b0, dvs_q});
    // Difference is below the divisor whenever it is used, so 32 bits are exact.
    r_diff  = r_shift[31:0] - dvs_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = 6'd0;
        if (start) begin
          ovf_d = 1'b0;
          dz_d  = 1'b0;
          dvs_d = divisor;
          rem_d = dividend[63:32];
          sh_d  = dividend[31:0];
          if (zero_hit) begin
            state_d = StDone;
            dz_d    = 1'b1;
            quo_d   = 32'hFFFF_FFFF;
            rmd_d   = dividend[31:0];
          end else if (dividend[63:32] >= divisor) begin
            state_d = StDone;
            ovf_d   = 1'b1;
            quo_d   = 32'hFFFF_FFFF;
            rmd_d   = 32'd0;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        rem_d = q_bit ? r_diff : r_shift[31:0];
        sh_d  = {sh_q[30:0], q_bit};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = StDone;
          quo_d   = sh_d;
          rmd_d   = rem_d;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      rem_q   <= 32'd0;
      sh_q    <= 32'd0;
      dvs_q   <= 32'd0;
      quo_q   <= 32'd0;
      rmd_q   <= 32'd0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign overflow  = ovf_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_divider_32.sv
// tb_divider_32: directed plus randomized checks of divider_32 against an arithmetic model.

module tb_divider_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        overflow;
  logic        div_zero;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  divider_32 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected results straight from integer division.
  function automatic void model(input logic [63:0] dd, input logic [31:0] dv,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic ov, output logic dz, output int lat);
    logic [63:0] qq;
    logic [63:0] rr;
    ov  = 1'b0;
    dz  = 1'b0;
    lat = 1;
    q   = 32'hFFFF_FFFF;
    r   = 32'd0;
    if (dv == 32'd0) begin
`ifdef DIV_ZERO_FLAG_EN
      dz = 1'b1;
      r  = dd[31:0];
`else
      ov = 1'b1;
`endif
    end else begin
      qq = dd / {32'd0, dv};
      rr = dd % {32'd0, dv};
      if (qq > 64'h0000_0000_FFFF_FFFF) begin
        ov = 1'b1;
      end else begin
        q   = qq[31:0];
        r   = rr[31:0];
        lat = 33;
      end
    end
  endfunction

  // Drives start for one cycle; returns at the falling edge after the accepting edge.
  task automatic issue(input logic [63:0] dd, input logic [31:0] dv);
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = {$urandom(), $urandom()};
    divisor  = $urandom();
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [63:0] dd, input logic [31:0] dv);
    logic [31:0] q, r;
    logic        ov, dz;
    int          lat, cyc;
    model(dd, dv, q, r, ov, dz, lat);
    issue(dd, dv);
    wait_done(cyc);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " latency"}, 64'(cyc + 1), 64'(lat));
    chk({tag, " quotient"}, 64'(quotient), 64'(q));
    chk({tag, " remainder"}, 64'(remainder), 64'(r));
    chk({tag, " overflow"}, 64'(overflow), 64'(ov));
    chk({tag, " div_zero"}, 64'(div_zero), 64'(dz));
    chk({tag, " busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
    chk({tag, " idle"}, 64'(busy), 64'd0);
    chk({tag, " hold_q"}, 64'(quotient), 64'(q));
    chk({tag, " hold_ovf"}, 64'(overflow), 64'(ov));
  endtask

  initial begin
    logic [31:0] q, r, dv, hi;
    logic        ov, dz;
    int          lat, cyc;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 64'd0;
    divisor  = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst quotient", 64'(quotient), 64'd0);
    chk("rst remainder", 64'(remainder), 64'd0);
    chk("rst overflow", 64'(overflow), 64'd0);
    chk("rst div_zero", 64'(div_zero), 64'd0);

    // Reset wins over a simultaneous start.
    start    = 1'b1;
    dividend = 64'd100;
    divisor  = 32'd7;
    @(negedge clk);
    chk("rst_prio busy", 64'(busy), 64'd0);
    rst   = 1'b0;
    start = 1'b0;

    run_op("basic", 64'd100, 32'd7);
    run_op("round1", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
    run_op("round2", 64'h0000_0001_0000_0005, 32'h0000_0002);
    run_op("ovf", 64'h0000_0001_0000_0000, 32'd1);
    run_op("divzero", 64'h1234, 32'd0);
    run_op("small", 64'd5, 32'd9);
    run_op("max_hi", 64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF);
    run_op("edge_ovf", 64'h0000_0010_0000_0000, 32'h10);

    // Start while busy: pulses at N+5 and N+33 are ignored.
    model(64'h0000_0003_1234_5678, 32'h10, q, r, ov, dz, lat);
    issue(64'h0000_0003_1234_5678, 32'h10);
    repeat (4) @(negedge clk);
    dividend = 64'd5;
    divisor  = 32'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk("busy_ign lat", 64'(cyc), 64'd27);
    chk("busy_ign quotient", 64'(quotient), 64'(q));
    chk("busy_ign remainder", 64'(remainder), 64'(r));
    chk("busy_ign overflow", 64'(overflow), 64'(ov));
    dividend = 64'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_ign busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("done_ign still_idle", 64'(busy), 64'd0);
    chk("done_ign quotient", 64'(quotient), 64'(q));

    // Reset at N+10 aborts a run; a start at N+12 then completes.
    issue(64'h0000_0000_8765_4321, 32'h333);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst quotient", 64'(quotient), 64'd0);
    chk("midrst remainder", 64'(remainder), 64'd0);
    chk("midrst overflow", 64'(overflow), 64'd0);
    run_op("after_rst", 64'h0000_0000_8765_4321, 32'h333);

    // Randomized operands, biased toward the normal path and its boundaries.
    for (int i = 0; i < 24; i++) begin
      dv = $urandom();
      if (dv == 32'd0) dv = 32'd1;
      case (i % 4)
        0: hi = $urandom() % dv;
        1: hi = $urandom();
        2: begin
          dv = $urandom_range(1, 255);
          hi = $urandom() % dv;
        end
        default: hi = dv - 32'd1;
      endcase
      run_op($sformatf("rand%0d", i), {hi, 32'($urandom())}, dv);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
